// File: rtl/lzma_framer_pkg.sv
// lzma_stream_framer shared types and helpers.
// State encoding, header length and LZMA property byte.
package lzma_framer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DRAIN
  } state_t;

  localparam int LZMA_HDR_LEN = 13;

  function automatic logic [7:0] lzma_props(
    input int lc,
    input int lp,
    input int pb
  );
    return 8'((pb * 5 + lp) * 9 + lc);
  endfunction

endpackage

// File: rtl/lzma_hdr_rom.sv
// lzma_stream_framer header byte lookup.
// Props byte, little-endian dictionary size, then unknown-size 0xFF bytes.
module lzma_hdr_rom
  import lzma_framer_pkg::*;
#(
  parameter int          LC        = 4,
  parameter int          LP        = 0,
  parameter int          PB        = 2,
  parameter logic [31:0] DICT_SIZE = 32'h00020000
) (
  input  logic [3:0] idx,
  output logic [7:0] data
);

  localparam logic [7:0] PROPS = lzma_props(LC, LP, PB);

  always_comb begin
    data = 8'hFF;
    case (idx)
      4'd0:    data = PROPS;
      4'd1:    data = DICT_SIZE[7:0];
      4'd2:    data = DICT_SIZE[15:8];
      4'd3:    data = DICT_SIZE[23:16];
      4'd4:    data = DICT_SIZE[31:24];
      default: data = 8'hFF;
    endcase
  end

endmodule

// File: rtl/lzma_stream_framer.sv
// LZMA-alone framer: header insertion, tlast generation, backpressure.
// Optional LZMA_FRAMER_STAT_EN adds o_stream_bytes and o_done.
module lzma_stream_framer
  import lzma_framer_pkg::*;
#(
  parameter int          LC        = 4,
  parameter int          LP        = 0,
  parameter int          PB        = 2,
  parameter logic [31:0] DICT_SIZE = 32'h00020000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tvalid,
  input  logic [7:0]  i_tdata,
  input  logic        i_tend,
  output logic        i_tready,
  output logic        o_tvalid,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  input  logic        o_tready
`ifdef LZMA_FRAMER_STAT_EN
  ,
  output logic [31:0] o_stream_bytes,
  output logic        o_done
`endif
);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        hold_v, hold_v_n;
  logic [7:0]  hold_d, hold_d_n;
  logic        ov_n, ol_n;
  logic [7:0]  od_n;
  logic [7:0]  hdr_byte;
  logic        out_free;

  lzma_hdr_rom #(
    .LC       (LC),
    .LP       (LP),
    .PB       (PB),
    .DICT_SIZE(DICT_SIZE)
  ) u_rom (
    .idx (cnt),
    .data(hdr_byte)
  );

  assign out_free = !o_tvalid || o_tready;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hold_v_n = hold_v;
    hold_d_n = hold_d;
    ov_n     = o_tvalid && !o_tready;
    od_n     = o_tdata;
    ol_n     = o_tlast;
    i_tready = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_tvalid) state_n = HDR;
      end
      HDR: begin
        if (out_free) begin
          if (cnt != 4'(LZMA_HDR_LEN)) begin
            ov_n  = 1'b1;
            od_n  = hdr_byte;
            ol_n  = 1'b0;
            cnt_n = cnt + 4'd1;
          end else begin
            // byte 12 handshaken this cycle
            cnt_n   = 4'd0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        i_tready = !hold_v || out_free;
        if (i_tvalid && i_tready) begin
          if (hold_v) begin
            ov_n = 1'b1;
            od_n = hold_d;
            ol_n = 1'b0;
          end
          hold_v_n = 1'b1;
          hold_d_n = i_tdata;
        end else if (i_tend && i_tready) begin
          hold_v_n = 1'b0;
          if (hold_v) begin
            ov_n    = 1'b1;
            od_n    = hold_d;
            ol_n    = 1'b1;
            state_n = DRAIN;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if (o_tvalid && o_tready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      hold_v   <= 1'b0;
      hold_d   <= 8'd0;
      o_tvalid <= 1'b0;
      o_tdata  <= 8'd0;
      o_tlast  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hold_v   <= hold_v_n;
      hold_d   <= hold_d_n;
      o_tvalid <= ov_n;
      o_tdata  <= od_n;
      o_tlast  <= ol_n;
    end
  end

`ifdef LZMA_FRAMER_STAT_EN
  assign o_done = o_tvalid && o_tready && o_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_stream_bytes <= 32'd0;
    end else if (state == IDLE && i_tvalid) begin
      o_stream_bytes <= 32'd0;
    end else if (o_tvalid && o_tready) begin
      o_stream_bytes <= o_stream_bytes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lzma_stream_framer.sv
// Directed bench for lzma_stream_framer (default and LC=3/4M instance).
// Checks header bytes, tlast placement, backpressure, reset, stats.
module tb_lzma_stream_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_tvalid;
  logic [7:0]  i_tdata;
  logic        i_tend;
  logic        i_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_tready;
  logic        i_tready4;
  logic        o_tvalid4;
  logic [7:0]  o_tdata4;
  logic        o_tlast4;
`ifdef LZMA_FRAMER_STAT_EN
  logic [31:0] sb, sb4;
  logic        dn, dn4;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_last = 0;
  int n_done = 0;
  int hdr_bad = 0;
  int pos = 0;
  bit rnd = 0;
  bit stall = 0;
  logic [8:0] stall_d;
  logic [8:0] q[$];
  logic [8:0] q4[$];

  always #5 clk = ~clk;

  lzma_stream_framer dut (
    .clk(clk), .rst(rst),
    .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .i_tend(i_tend), .i_tready(i_tready),
    .o_tvalid(o_tvalid), .o_tdata(o_tdata),
    .o_tlast(o_tlast), .o_tready(o_tready)
`ifdef LZMA_FRAMER_STAT_EN
    , .o_stream_bytes(sb), .o_done(dn)
`endif
  );

  lzma_stream_framer #(
    .LC(3), .LP(0), .PB(2), .DICT_SIZE(32'h00400000)
  ) dut4 (
    .clk(clk), .rst(rst),
    .i_tvalid(i_tvalid), .i_tdata(i_tdata),
    .i_tend(i_tend), .i_tready(i_tready4),
    .o_tvalid(o_tvalid4), .o_tdata(o_tdata4),
    .o_tlast(o_tlast4), .o_tready(o_tready)
`ifdef LZMA_FRAMER_STAT_EN
    , .o_stream_bytes(sb4), .o_done(dn4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pos = 0;
      stall = 0;
    end else begin
      if (stall) begin
        chk("stall_data", {23'd0, o_tlast, o_tdata}, {23'd0, stall_d});
        chk("stall_valid", {31'd0, o_tvalid}, 32'd1);
      end
      if (o_tvalid && o_tready) begin
        q.push_back({o_tlast, o_tdata});
        if (pos < 13 && i_tready) hdr_bad++;
        pos = o_tlast ? 0 : pos + 1;
        if (o_tlast) n_last++;
      end
      if (o_tvalid4 && o_tready) q4.push_back({o_tlast4, o_tdata4});
`ifdef LZMA_FRAMER_STAT_EN
      if (dn) n_done++;
`endif
      stall = o_tvalid && !o_tready;
      stall_d = {o_tlast, o_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) o_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 0;
    i_tvalid = 1'b1;
    i_tdata = b;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (i_tready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    i_tvalid = 1'b0;
  endtask

  task automatic send_end();
    bit ok = 0;
    i_tend = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (i_tready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("end_timeout", 0, 1);
    tick();
    i_tend = 1'b0;
  endtask

  task automatic wait_last(input int target);
    bit ok = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n_last >= target) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("last_timeout", 0, 1);
  endtask

  logic [7:0] hdr1[13];
  logic [7:0] hdr4[5];
  int err;
  int tgt;
  int base;

  initial begin
    hdr1 = '{8'h5E, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF,
             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    hdr4 = '{8'h5D, 8'h00, 8'h00, 8'h40, 8'h00};
    rst = 1'b1;
    i_tvalid = 1'b0;
    i_tdata = 8'd0;
    i_tend = 1'b0;
    o_tready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ovalid", {31'd0, o_tvalid}, 0);
    chk("rst_odata", {24'd0, o_tdata}, 0);
    chk("rst_olast", {31'd0, o_tlast}, 0);
    chk("rst_itready", {31'd0, i_tready}, 0);
    chk("rst_itready4", {31'd0, i_tready4}, 0);
    tick();
    rst = 1'b0;
    tick();

    // stream 11 22 33
    n_done = 0;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send_end();
    wait_last(1);
    chk("t1_count", q.size(), 16);
    err = 0;
    for (int i = 0; i < 13; i++)
      if (q[i] !== {1'b0, hdr1[i]}) err++;
    chk("t1_header", err, 0);
    chk("t1_b13", {23'd0, q[13]}, {23'd0, 9'h011});
    chk("t1_b14", {23'd0, q[14]}, {23'd0, 9'h022});
    chk("t1_b15", {23'd0, q[15]}, {23'd0, 9'h133});
    err = 0;
    for (int i = 0; i < 5; i++)
      if (q4[i] !== {1'b0, hdr4[i]}) err++;
    chk("t4_header", err, 0);
    chk("t4_count", q4.size(), 16);
`ifdef LZMA_FRAMER_STAT_EN
    chk("stat_bytes", sb, 16);
    chk("stat_done", n_done, 1);
`endif

    // single-byte stream
    q.delete();
    hdr_bad = 0;
    send(8'hAB);
    send_end();
    wait_last(2);
    chk("t2_count", q.size(), 14);
    chk("t2_first", {23'd0, q[0]}, {23'd0, 9'h05E});
    chk("t2_last", {23'd0, q[13]}, {23'd0, 9'h1AB});
    chk("t2_hdr_tready", hdr_bad, 0);

    // 1000 bytes under random backpressure
    q.delete();
    rnd = 1;
    for (int i = 0; i < 1000; i++) send(8'((i * 7 + 3) & 255));
    send_end();
    wait_last(3);
    rnd = 0;
    o_tready = 1'b1;
    chk("t3_count", q.size(), 1013);
    chk("t3_first", {23'd0, q[0]}, {23'd0, 9'h05E});
    err = 0;
    for (int i = 0; i < 1000; i++)
      if (q[13 + i] !== {i == 999, 8'((i * 7 + 3) & 255)}) err++;
    chk("t3_payload", err, 0);
    chk("t3_hdr_tready", hdr_bad, 0);
    tick();

    // i_tend in IDLE is ignored
    q.delete();
    i_tend = 1'b1;
    repeat (5) tick();
    i_tend = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_idle_end_q", q.size(), 0);
    chk("t5_idle_end_v", {31'd0, o_tvalid}, 0);

    // second stream arrives while first is draining
    tick();
    send(8'h01);
    o_tready = 1'b0;
    send_end();
    i_tvalid = 1'b1;
    i_tdata = 8'h02;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_drain_v", {31'd0, o_tvalid}, 1);
    chk("t5_drain_d", {23'd0, o_tlast, o_tdata}, {23'd0, 9'h101});
    chk("t5_drain_rdy", {31'd0, i_tready}, 0);
    chk("t5_drain_q", q.size(), 13);
    tick();
    o_tready = 1'b1;
    send(8'h02);
    send_end();
    wait_last(5);
    chk("t5_count", q.size(), 28);
    chk("t5_last1", {23'd0, q[13]}, {23'd0, 9'h101});
    chk("t5_hdr2", {23'd0, q[14]}, {23'd0, 9'h05E});
    chk("t5_last2", {23'd0, q[27]}, {23'd0, 9'h102});

    // reset with hold full
    send(8'hA1);
    send(8'hA2);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_ovalid", {31'd0, o_tvalid}, 0);
    chk("t6_itready", {31'd0, i_tready}, 0);
`ifdef LZMA_FRAMER_STAT_EN
    chk("t6_stat_rst", sb, 0);
`endif
    tick();
    rst = 1'b0;
    q.delete();
    tgt = n_last + 1;
    base = hdr_bad;
    send(8'hB1);
    send_end();
    wait_last(tgt);
    chk("t6_count", q.size(), 14);
    chk("t6_first", {23'd0, q[0]}, {23'd0, 9'h05E});
    chk("t6_last", {23'd0, q[13]}, {23'd0, 9'h1B1});
    chk("t6_hdr_tready", hdr_bad, base);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
